// File: rtl/control_unit_if.sv
// control_unit_if: control-unit <-> datapath bundle (run/memory handshake, IR feedback, strobes, status)
interface control_unit_if;
  logic        run;
  logic        mem_rdy;
  logic [31:0] ir;
  logic [15:0] r_out;
  logic [15:0] r_in;
  logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
  logic        Yin, Zin, Zlowout, Zhighout, LOin, HIin;
  logic [12:0] alu_op;
  logic        busy;
  logic        done;
  logic        illegal;
  modport master (
    input  run, mem_rdy, ir,
    output r_out, r_in, PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
           Yin, Zin, Zlowout, Zhighout, LOin, HIin, alu_op, busy, done, illegal
  );
  modport slave (
    output run, mem_rdy, ir,
    input  r_out, r_in, PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
           Yin, Zin, Zlowout, Zhighout, LOin, HIin, alu_op, busy, done, illegal
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/decode/ALU sequencer; define CU_MULDIV_EN to enable MUL/DIV (T6, LOin/HIin/Zhighout)
module control_unit #(
  parameter int OPW = 5
) (
  input logic          clk,
  input logic          reset,
  control_unit_if.master bus
);
  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;
  state_t state, nxt;
  logic [OPW-1:0] op;
  logic [3:0] ra, rb, rc;
  logic bin, un, md, legal, last, ill_q;
  logic [12:0] alu;
  assign op = bus.ir[31 -: OPW];
  assign ra = bus.ir[26:23];
  assign rb = bus.ir[22:19];
  assign rc = bus.ir[18:15];
  // opcode class and one-hot ALU select; bit 12 = AND ... bit 0 = NOT
  always_comb begin
    bin = 1'b0;
    un  = 1'b0;
    md  = 1'b0;
    alu = '0;
    case (op)
      5'b00011: begin bin = 1'b1; alu = 13'h0400; end
      5'b00100: begin bin = 1'b1; alu = 13'h0200; end
      5'b00101: begin bin = 1'b1; alu = 13'h1000; end
      5'b00110: begin bin = 1'b1; alu = 13'h0800; end
      5'b00111: begin bin = 1'b1; alu = 13'h0008; end
      5'b01000: begin bin = 1'b1; alu = 13'h0004; end
      5'b01001: begin bin = 1'b1; alu = 13'h0040; end
      5'b01010: begin bin = 1'b1; alu = 13'h0020; end
      5'b01011: begin bin = 1'b1; alu = 13'h0010; end
`ifdef CU_MULDIV_EN
      5'b01111: begin md = 1'b1; alu = 13'h0100; end
      5'b10000: begin md = 1'b1; alu = 13'h0080; end
`endif
      5'b10001: begin un = 1'b1; alu = 13'h0002; end
      5'b10010: begin un = 1'b1; alu = 13'h0001; end
      default: ;
    endcase
  end
  assign legal = bin | un | md;
  assign last  = (state == T4 && un) || (state == T5 && bin) || (state == T6);
  // state register; reset wins in every state, including a T1 stall
  always_ff @(posedge clk)
    state <= !reset ? IDLE : nxt;
  // sticky illegal-opcode flag, cleared only by reset
  always_ff @(posedge clk)
    ill_q <= !reset ? 1'b0 : (ill_q | (state == T3 && !legal));
  // next-state: run is only looked at in IDLE and in the done step
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.run ? T0 : IDLE;
      T0:      nxt = T1;
      T1:      nxt = bus.mem_rdy ? T2 : T1;
      T2:      nxt = T3;
      T3:      nxt = legal ? T4 : HALT;
      T4:      nxt = un ? (bus.run ? T0 : IDLE) : T5;
      T5:      nxt = md ? T6 : (bus.run ? T0 : IDLE);
      T6:      nxt = bus.run ? T0 : IDLE;
      default: nxt = HALT;
    endcase
  end
  // Moore strobe decode from state and ir
  always_comb begin
    bus.r_out    = '0;
    bus.r_in     = '0;
    bus.PCout    = 1'b0;
    bus.PCin     = 1'b0;
    bus.IncPC    = 1'b0;
    bus.MARin    = 1'b0;
    bus.Read     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zin      = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zhighout = 1'b0;
    bus.LOin     = 1'b0;
    bus.HIin     = 1'b0;
    bus.alu_op   = '0;
    bus.busy     = state != IDLE && state != HALT;
    bus.done     = last;
    bus.illegal  = ill_q;
    case (state)
      T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.PCin  = 1'b1;
      end
      T1: begin
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
      end
      T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      T3: begin
        bus.r_out  = legal ? 16'(1) << rb : '0;
        bus.Yin    = bin | md;
        bus.Zin    = un;
        bus.alu_op = un ? alu : '0;
      end
      T4: begin
        bus.r_out   = un ? '0 : 16'(1) << rc;
        bus.Zin     = !un;
        bus.alu_op  = un ? '0 : alu;
        bus.Zlowout = un;
        bus.r_in    = un ? 16'(1) << ra : '0;
      end
      T5: begin
        bus.Zlowout = 1'b1;
        bus.r_in    = bin ? 16'(1) << ra : '0;
`ifdef CU_MULDIV_EN
        bus.LOin    = md;
`endif
      end
`ifdef CU_MULDIV_EN
      T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed checks of fetch, binary/unary/muldiv sequencing, stalls, illegal opcodes and reset
module tb_control_unit;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  control_unit_if bus();
  control_unit dut (.clk(clk), .reset(reset), .bus(bus.master));
  always #5 clk = ~clk;
  localparam logic [13:0] S_T0 = 14'h3C00, S_T1 = 14'h0300, S_T2 = 14'h00C0;
  localparam logic [13:0] S_Y = 14'h0020, S_Z = 14'h0010, S_ZL = 14'h0008;
  localparam logic [13:0] S_ZH = 14'h0004, S_LO = 14'h0002, S_HI = 14'h0001;
  localparam logic [12:0] A_ADD = 13'h0400, A_SHR = 13'h0040, A_MUL = 13'h0100;
  logic [13:0] strb;
  assign strb = {bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.Read, bus.MDRin, bus.MDRout,
                 bus.IRin, bus.Yin, bus.Zin, bus.Zlowout, bus.Zhighout, bus.LOin, bus.HIin};
  task automatic chk(input string tag, input logic [15:0] ro, input logic [15:0] ri,
                     input logic [13:0] st, input logic [12:0] al,
                     input logic b, input logic d, input logic il);
    logic [61:0] obs, exp;
    obs = {bus.r_out, bus.r_in, strb, bus.alu_op, bus.busy, bus.done, bus.illegal};
    exp = {ro, ri, st, al, b, d, il};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed r_out=%h r_in=%h strb=%h alu=%h busy/done/ill=%b expected r_out=%h r_in=%h strb=%h alu=%h busy/done/ill=%b",
             tag, obs[61:46], obs[45:30], obs[29:16], obs[15:3], obs[2:0],
             exp[61:46], exp[45:30], exp[29:16], exp[15:3], exp[2:0]);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic fetch(input string tag);
    cyc(); chk({tag, " T0"}, 0, 0, S_T0, 0, 1, 0, 0);
    cyc(); chk({tag, " T1"}, 0, 0, S_T1, 0, 1, 0, 0);
    cyc(); chk({tag, " T2"}, 0, 0, S_T2, 0, 1, 0, 0);
  endtask
  initial begin
    reset = 1'b0; bus.run = 1'b0; bus.mem_rdy = 1'b1; bus.ir = '0;
    cyc(); chk("reset", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    cyc(); chk("idle", 0, 0, 0, 0, 0, 0, 0);
    // SHR R4,R3,R7 single instruction
    bus.ir = 32'h4A1B8000; bus.run = 1'b1;
    cyc(); chk("shr T0", 0, 0, S_T0, 0, 1, 0, 0);
    bus.run = 1'b0;
    cyc(); chk("shr T1", 0, 0, S_T1, 0, 1, 0, 0);
    cyc(); chk("shr T2", 0, 0, S_T2, 0, 1, 0, 0);
    cyc(); chk("shr T3", 16'h0008, 0, S_Y, 0, 1, 0, 0);
    cyc(); chk("shr T4", 16'h0080, 0, S_Z, A_SHR, 1, 0, 0);
    cyc(); chk("shr T5", 0, 16'h0010, S_ZL, 0, 1, 1, 0);
    cyc(); chk("shr idle", 0, 0, 0, 0, 0, 0, 0);
    // ADD R2,R5,R6 back to back; run dropped mid-second-instruction
    bus.ir = 32'h192B0000; bus.run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      int p;
      cyc();
      p = i % 6;
      if (i == 7) bus.run = 1'b0;
      chk($sformatf("add b2b c%0d", i),
          p == 3 ? 16'h0020 : p == 4 ? 16'h0040 : 16'h0,
          p == 5 ? 16'h0004 : 16'h0,
          p == 0 ? S_T0 : p == 1 ? S_T1 : p == 2 ? S_T2 : p == 3 ? S_Y : p == 4 ? S_Z : S_ZL,
          p == 4 ? A_ADD : 13'h0, 1'b1, p == 5, 1'b0);
    end
    cyc(); chk("add idle", 0, 0, 0, 0, 0, 0, 0);
    // MUL R3,R4
    bus.ir = 32'h781A0000; bus.run = 1'b1;
    fetch("mul");
    bus.run = 1'b0;
`ifdef CU_MULDIV_EN
    cyc(); chk("mul T3", 16'h0008, 0, S_Y, 0, 1, 0, 0);
    cyc(); chk("mul T4", 16'h0010, 0, S_Z, A_MUL, 1, 0, 0);
    cyc(); chk("mul T5", 0, 0, S_ZL | S_LO, 0, 1, 0, 0);
    cyc(); chk("mul T6", 0, 0, S_ZH | S_HI, 0, 1, 1, 0);
    cyc(); chk("mul idle", 0, 0, 0, 0, 0, 0, 0);
`else
    cyc(); chk("mul T3 illegal", 0, 0, 0, 0, 1, 0, 0);
    cyc(); chk("mul halt", 0, 0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    cyc(); chk("mul reset", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
`endif
    // T1 stall: mem_rdy low for 3 cycles in T1
    bus.ir = 32'h4A1B8000; bus.run = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      if (c == 1) bus.run = 1'b0;
      bus.mem_rdy = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
      checks++;
      assert ({bus.Read, bus.MDRin, bus.done, bus.busy} === {c >= 2 && c <= 5, c >= 2 && c <= 5, c == 9, c <= 9})
      else begin
        errors++;
        $error("FAIL stall c%0d: observed read/mdrin/done/busy=%b%b%b%b expected %b%b%b%b", c,
               bus.Read, bus.MDRin, bus.done, bus.busy,
               c >= 2 && c <= 5, c >= 2 && c <= 5, c == 9, c <= 9);
      end
    end
    // undecodable opcode
    bus.ir = 32'hF8000000; bus.run = 1'b1;
    fetch("bad");
    cyc(); chk("bad T3", 0, 0, 0, 0, 1, 0, 0);
    cyc(); chk("bad halt", 0, 0, 0, 0, 0, 0, 1);
    cyc(); cyc(); chk("bad halt hold", 0, 0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    cyc(); chk("bad reset", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1; bus.ir = 32'h192B0000;
    cyc(); chk("restart T0", 0, 0, S_T0, 0, 1, 0, 0);
    // reset during T4 of ADD
    cyc(); cyc(); cyc();
    cyc(); chk("add T4 pre-reset", 16'h0040, 0, S_Z, A_ADD, 1, 0, 0);
    reset = 1'b0;
    cyc(); chk("reset in T4", 0, 0, 0, 0, 0, 0, 0);
    bus.run = 1'b0; reset = 1'b1;
    cyc(); chk("post reset idle", 0, 0, 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the Phase-1 datapath. It drives the datapath's per-cycle control strobes and replaces the hand-scheduled T0–Tn sequences used in datapath benches. It fetches an instruction from memory, loads IR, decodes the opcode and register fields of the `ir` word returned by the datapath, and steps through the ALU microsequence. It sits beside `datapath`: its outputs connect one-to-one to the datapath's control inputs, and `ir` is fed back from the IR register.

## Interface
Parameters:
- `OPW`, 5: opcode width (`ir[31:27]`).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `run`  in  1  level; while high, the unit fetches and executes instructions back to back.
- `mem_rdy`  in  1  memory read data valid; T1 stalls until it is high.
- `ir`  in  32  IR contents from the datapath.
  - Field split: opcode `[31:27]`, Ra `[26:23]`, Rb `[22:19]`, Rc `[18:15]`.
- `r_out`  out  16  one-hot register-to-bus enable (R0out..R15out).
- `r_in`  out  16  one-hot register load enable (R0in..R15in).
- `PCout`, `PCin`, `IncPC`, `MARin`, `Read`, `MDRin`, `MDRout`, `IRin`, `Yin`, `Zin`, `Zlowout`, `Zhighout`, `LOin`, `HIin`  out  1 each  datapath strobes.
- `alu_op`  out  13  one-hot ALU select, bit order {AND,OR,ADD,SUB,MUL,DIV,SHR,SHRA,SHL,ROR,ROL,NEG,NOT}, bit 12 = AND.
- `busy`  out  1  high in any state except IDLE/HALT.
- `done`  out  1  one-cycle pulse in the final step of each instruction.
- `illegal`  out  1  sticky; set on an undecodable opcode.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT.
- All outputs are Moore decodes of the registered state plus `ir`. Every strobe is asserted for exactly one cycle per state. All strobes not listed for a state are 0.
- IDLE: all outputs 0. If `run`=1, go to T0.
- Fetch steps (all instructions):
  - T0: PCout, MARin, IncPC, PCin.
  - T1: Read, MDRin. Hold T1 while `mem_rdy`=0; Read and MDRin stay asserted during the stall.
  - T2: MDRout, IRin.
- Opcode map:
  - Binary ops: ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011.
  - Multiply/divide: MUL 01111, DIV 10000.
  - Unary ops: NEG 10001, NOT 10010.
- Binary ops:
  - T3: `r_out`=onehot(Rb), Yin.
  - T4: `r_out`=onehot(Rc), `alu_op`=op, Zin.
  - T5: Zlowout, `r_in`=onehot(Ra), `done`.
- Unary ops:
  - T3: `r_out`=onehot(Rb), `alu_op`=op, Zin.
  - T4: Zlowout, `r_in`=onehot(Ra), `done`.
- MUL/DIV:
  - T3 and T4 as for binary ops.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin, `done`.
- After the `done` step: if `run`=1 go to T0, otherwise go to IDLE.
- Any other opcode observed in T3: set `illegal`, assert no strobes, go to HALT. HALT is left only by reset.
- `run` is sampled only in IDLE and in the `done` step. Deasserting it mid-instruction has no effect; the current instruction completes.

## Timing
- Reset (`reset`=0 at a rising edge) forces IDLE on that edge. All outputs are 0 in the following cycle, including `busy`, `done` and `illegal`. Reset takes effect mid-instruction in any state, including during a T1 stall.
- Latency from `run` rising in IDLE to `done`, with `mem_rdy` tied high:
  - binary ops: 6 cycles (T0–T5);
  - unary ops: 5 cycles;
  - MUL/DIV: 7 cycles.
- Each cycle `mem_rdy` is low in T1 adds one cycle.
- The decode uses `ir` from T3 onward, after the IRin edge at the end of T2. `ir` must be stable from T3 until `done`.
- Back-to-back: the cycle after `done` is T0 with no bubble.
- If Ra, Rb and Rc are identical, the one-hot outputs simply select the same register; no special handling.

## Configuration
- `CU_MULDIV_EN` defined: MUL/DIV are decoded and run through T6.
- `CU_MULDIV_EN` undefined:
  - opcodes 01111 and 10000 are illegal (`illegal`=1, HALT);
  - state T6, LOin, HIin and Zhighout are never asserted, and LOin, HIin and Zhighout are tied 0;
  - the MUL and DIV `alu_op` bits are tied 0.

## Test plan
- SHR R4,R3,R7, `ir`=0x4A1B8000, `run`=1 one instruction, `mem_rdy`=1 → T3 `r_out`=0x0008 with Yin; T4 `r_out`=0x0080 with `alu_op` SHR bit and Zin; T5 Zlowout with `r_in`=0x0010 and `done`; then IDLE.
- ADD R2,R5,R6, `ir`=0x192B0000, `run` held high → T5 `r_in`=0x0004; the next cycle is T0 with PCout; `done` pulses every 6 cycles.
- MUL R3,R4, `ir`=0x781A0000, macro defined → T5 LOin, T6 HIin and `done`; `r_in`=0 throughout. Macro undefined → `illegal`=1 after T3, HALT, `busy`=0.
- `mem_rdy` held 0 for 3 cycles in T1 → Read and MDRin stay high for 4 cycles; `done` arrives 3 cycles later than nominal.
- `ir`=0xF8000000 → `illegal`=1 and HALT with all strobes 0. Pulsing `reset` low clears `illegal`, and the unit restarts from IDLE.
- `reset` low during T4 of an ADD → IDLE with all outputs 0 the next cycle, and no `r_in` asserted.
